// File: rtl/fifo_read_ctrl_if.sv
// Downstream first-word-fall-through stream of the async FIFO read side.
// Transfer happens on a clock edge where m_valid & m_ready; m_valid/m_data hold until accepted.
interface fifo_read_ctrl_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;

   modport master (
      output m_data,
      output m_valid,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_valid,
      output m_ready
   );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the async FIFO: pointer compare, RAM read issue,
// 2-entry output queue feeding a FWFT stream, Gray read pointer back to the write side.
module fifo_read_ctrl #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              r_clk,
   input  logic              rst_n,
   input  logic [ADDR_W:0]   wq2_wptr_i,
   output logic              r_en_o,
   output logic [ADDR_W:0]   r_addr_o,
   input  logic [DATA_W-1:0] ram_dout_i,
   output logic [ADDR_W:0]   rptr_gray_o,
   output logic              r_empty_o,
   output logic [ADDR_W:0]   rd_level_o,
   output logic [1:0]        dbg_count_o,
   output logic              dbg_inflight_o,
   fifo_read_ctrl_if.master  m_if
);

   function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
      logic [ADDR_W:0] b;
      b = '0;
      b[ADDR_W] = g[ADDR_W];
      for (int i = ADDR_W - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [ADDR_W:0]   rbin_q, rbin_d;
   logic [ADDR_W:0]   rgray_q;
   logic              inflight_q;
   logic [1:0]        count_q, count_d;
   logic              head_q, tail_q;
   logic [DATA_W-1:0] mem_q [2];

   logic [ADDR_W:0]   wbin;
   logic              empty;
   logic              pop;
   logic              push;
   logic [2:0]        occ;
   logic              r_en;

   always_comb begin
      wbin    = gray2bin(wq2_wptr_i);
      empty   = (rbin_q == wbin);
      pop     = (count_q != 2'd0) && m_if.m_ready;
      push    = inflight_q;
      // Occupancy after this edge if no read is issued; a new read may join only if it stays <= 2.
      occ     = 3'(count_q) + 3'(inflight_q) - 3'(pop);
      r_en    = rst_n && !empty && (occ <= 3'd1);
      rbin_d  = r_en ? rbin_q + 1'b1 : rbin_q;
      count_d = count_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge r_clk or negedge rst_n) begin
      if (!rst_n) begin
         rbin_q     <= '0;
         rgray_q    <= '0;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
      end else begin
         rbin_q     <= rbin_d;
         rgray_q    <= rbin_d ^ (rbin_d >> 1);
         inflight_q <= r_en;
         count_q    <= count_d;
         if (push) begin
            mem_q[tail_q] <= ram_dout_i;
            tail_q        <= ~tail_q;
         end
         if (pop) begin
            head_q <= ~head_q;
         end
      end
   end

   assign r_en_o         = r_en;
   assign r_addr_o       = rbin_q;
   assign rptr_gray_o    = rgray_q;
   assign r_empty_o      = empty;
   assign rd_level_o     = wbin - rbin_q;
   assign dbg_count_o    = count_q;
   assign dbg_inflight_o = inflight_q;
   assign m_if.m_valid   = (count_q != 2'd0);
   assign m_if.m_data    = mem_q[head_q];

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: a RAM model with registered d_out, a write-pointer
// driver, and an expected-word queue checked on every accepted transfer.
module tb_fifo_read_ctrl;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   logic                r_clk = 1'b0;
   logic                rst_n;
   logic [ADDR_W:0]     wq2_wptr;
   logic                r_en;
   logic [ADDR_W:0]     r_addr;
   logic [DATA_W-1:0]   ram_dout = '0;
   logic [ADDR_W:0]     rptr_gray;
   logic                r_empty;
   logic [ADDR_W:0]     rd_level;
   logic [1:0]          dbg_count;
   logic                dbg_inflight;

   fifo_read_ctrl_if #(.DATA_W(DATA_W)) m_if ();

   fifo_read_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .r_clk          (r_clk),
      .rst_n          (rst_n),
      .wq2_wptr_i     (wq2_wptr),
      .r_en_o         (r_en),
      .r_addr_o       (r_addr),
      .ram_dout_i     (ram_dout),
      .rptr_gray_o    (rptr_gray),
      .r_empty_o      (r_empty),
      .rd_level_o     (rd_level),
      .dbg_count_o    (dbg_count),
      .dbg_inflight_o (dbg_inflight),
      .m_if           (m_if.master)
   );

   always #5 r_clk = ~r_clk;

   logic [DATA_W-1:0] ram_mem [32];
   always @(posedge r_clk) begin
      if (r_en) ram_dout <= ram_mem[r_addr[ADDR_W-1:0]];
   end

   int                vectors     = 0;
   int                miscompares = 0;
   logic [DATA_W-1:0] exp_q [$];
   logic [ADDR_W:0]   wr_cnt = '0;
   logic [ADDR_W:0]   rd_cnt = '0;
   int                pops   = 0;
   logic              hold_flag = 1'b0;
   logic [DATA_W-1:0] hold_data = '0;
   logic              saw_wrap  = 1'b0;

   function automatic logic [ADDR_W:0] gray(input logic [ADDR_W:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d);
      ram_mem[wr_cnt[ADDR_W-1:0]] = d;
      exp_q.push_back(d);
      wr_cnt   = wr_cnt + 1'b1;
      wq2_wptr = gray(wr_cnt);
   endtask

   // One clock: settle, check pointer/level outputs and any transfer, advance past the edge.
   task automatic tick();
      logic [DATA_W-1:0] e;
      #1;
      check("r_addr", 32'(r_addr), 32'(rd_cnt));
      check("rptr_gray", 32'(rptr_gray), 32'(gray(rd_cnt)));
      check("rd_level", 32'(rd_level), 32'(6'(wr_cnt - rd_cnt)));
      check("r_empty", 32'(r_empty), 32'(wr_cnt == rd_cnt));
      if (m_if.m_valid && m_if.m_ready) begin
         if (exp_q.size() == 0) begin
            check("pop_unexpected", 32'(1), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("m_data", 32'(m_if.m_data), 32'(e));
            pops++;
         end
      end
      if (r_en) begin
         if (rd_cnt == 6'd63) saw_wrap = 1'b1;
         rd_cnt = rd_cnt + 1'b1;
      end
      hold_flag = m_if.m_valid && !m_if.m_ready;
      hold_data = m_if.m_data;
      @(posedge r_clk);
      #1;
      if (hold_flag && rst_n) begin
         check("hold_valid", 32'(m_if.m_valid), 32'(1));
         check("hold_data", 32'(m_if.m_data), 32'(hold_data));
      end
   endtask

   initial begin
      int base_rd;
      int base_pop;
      int written;
      int cyc;
      rst_n        = 1'b0;
      wq2_wptr     = '0;
      m_if.m_ready = 1'b0;
      for (int i = 0; i < 32; i++) ram_mem[i] = '0;

      // Reset state
      #12;
      check("rst_m_valid", 32'(m_if.m_valid), 32'(0));
      check("rst_m_data", 32'(m_if.m_data), 32'(0));
      check("rst_r_en", 32'(r_en), 32'(0));
      check("rst_r_addr", 32'(r_addr), 32'(0));
      check("rst_rptr_gray", 32'(rptr_gray), 32'(0));
      check("rst_rd_level", 32'(rd_level), 32'(0));
      check("rst_r_empty", 32'(r_empty), 32'(1));
      @(posedge r_clk); #1;
      rst_n = 1'b1;
      tick();

      // Single word: read issued at once, visible after two edges, for one cycle
      m_if.m_ready = 1'b1;
      push_word(8'hA5);
      #1;
      check("single_r_en", 32'(r_en), 32'(1));
      check("single_r_addr", 32'(r_addr), 32'(0));
      check("single_valid0", 32'(m_if.m_valid), 32'(0));
      tick();
      check("single_r_en_off", 32'(r_en), 32'(0));
      check("single_valid1", 32'(m_if.m_valid), 32'(0));
      check("single_gray", 32'(rptr_gray), 32'(6'b000001));
      tick();
      check("single_valid2", 32'(m_if.m_valid), 32'(1));
      check("single_data", 32'(m_if.m_data), 32'(8'hA5));
      tick();
      check("single_valid3", 32'(m_if.m_valid), 32'(0));

      // Stream: 32 preloaded words at one word per cycle
      for (int i = 0; i < 32; i++) push_word(8'(i * 7 + 3));
      #1;
      check("stream_wptr", 32'(wq2_wptr), 32'(6'b110001));
      check("stream_level", 32'(rd_level), 32'(32));
      tick();
      tick();
      for (int i = 0; i < 32; i++) begin
         check("stream_valid", 32'(m_if.m_valid), 32'(1));
         check("stream_count", 32'(dbg_count), 32'(1));
         tick();
      end
      check("stream_done_valid", 32'(m_if.m_valid), 32'(0));
      check("stream_done_empty", 32'(r_empty), 32'(1));
      check("stream_done_q", 32'(exp_q.size()), 32'(0));

      // Backpressure: only two words fetched while stalled
      m_if.m_ready = 1'b0;
      base_rd  = int'(rd_cnt);
      base_pop = pops;
      for (int i = 0; i < 5; i++) push_word(8'(8'h40 + i));
      for (int i = 0; i < 6; i++) tick();
      check("bp_reads", 32'(6'(rd_cnt - 6'(base_rd))), 32'(2));
      check("bp_level", 32'(rd_level), 32'(3));
      check("bp_count", 32'(dbg_count), 32'(2));
      check("bp_inflight", 32'(dbg_inflight), 32'(0));
      check("bp_valid", 32'(m_if.m_valid), 32'(1));
      check("bp_data", 32'(m_if.m_data), 32'(8'h40));
      m_if.m_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 30) begin
         tick();
         cyc++;
      end
      check("bp_drained", 32'(exp_q.size()), 32'(0));
      check("bp_pops", 32'(pops - base_pop), 32'(5));
      tick();
      check("bp_idle_valid", 32'(m_if.m_valid), 32'(0));

      // Wrap: 70 words with random ready and random write timing
      written = 0;
      cyc     = 0;
      while (!(written == 70 && exp_q.size() == 0) && cyc < 3000) begin
         m_if.m_ready = 1'($urandom_range(0, 1));
         if (written < 70 && int'(6'(wr_cnt - rd_cnt)) < 32 && $urandom_range(0, 3) != 0) begin
            push_word(8'($urandom_range(0, 255)));
            written++;
         end
         tick();
         cyc++;
      end
      check("wrap_timeout", 32'(cyc < 3000), 32'(1));
      check("wrap_drained", 32'(exp_q.size()), 32'(0));
      check("wrap_seen", 32'(saw_wrap), 32'(1));

      // Reset mid-stream discards queued and in-flight words
      m_if.m_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_word(8'(8'h90 + i));
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("mrst_valid", 32'(m_if.m_valid), 32'(0));
      check("mrst_r_en", 32'(r_en), 32'(0));
      check("mrst_gray", 32'(rptr_gray), 32'(0));
      check("mrst_count", 32'(dbg_count), 32'(0));
      check("mrst_inflight", 32'(dbg_inflight), 32'(0));
      exp_q.delete();
      rd_cnt    = '0;
      wr_cnt    = '0;
      wq2_wptr  = '0;
      hold_flag = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Recovery after reset
      m_if.m_ready = 1'b1;
      push_word(8'h3C);
      tick();
      tick();
      check("post_valid", 32'(m_if.m_valid), 32'(1));
      check("post_data", 32'(m_if.m_data), 32'(8'h3C));
      tick();
      check("post_drained", 32'(exp_q.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
